// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the CSR read/write decode (master) and the trap unit (slave).
//   addr   12  CSR address
//   wr_en   1  write strobe
//   wdata  32  write data
//   rdata  32  read data (combinational), zero for addresses the slave does not own
interface csr_trap_unit_if;
    logic [11:0] addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wr_en, output wdata, input rdata);
    modport slave  (input addr, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/csr_trap_unit.sv
// M/U-mode trap controller: owns mstatus/mie/mip/mtvec/mepc/mcause/mtval, arbitrates one
// synchronous exception against NUM_IRQ level interrupts, and returns the redirect PC to fetch.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   en_i, pc_i                  execute-stage instruction valid and its PC
//   exc_i, exc_code_i, exc_tval_i  exception from that instruction (qualified by en_i)
//   mret_i                      MRET in execute (qualified by en_i)
//   irq_i                       level-sensitive interrupt requests
//   csr                         CSR access bus (slave side)
//   trap_o, redirect_o, redirect_pc_o  trap taken / pipeline redirect and its target
//   mode_o                      current privilege (11 = M, 00 = U)
module csr_trap_unit #(
    parameter int          NUM_IRQ       = 4,
    parameter int          IRQ_CODE_BASE = 16,
    parameter logic [31:0] MTVEC_RST     = 32'h0,
    parameter bit          HAS_UMODE     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [31:0]        pc_i,
    input  logic               exc_i,
    input  logic [4:0]         exc_code_i,
    input  logic [31:0]        exc_tval_i,
    input  logic               mret_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    csr_trap_unit_if.slave     csr,
    output logic               trap_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic [1:0]         mode_o
);
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << IRQ_CODE_BASE;

    priv_t       mode_q;
    logic        st_mie;
    logic        st_mpie;
    priv_t       st_mpp;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    logic        is_m;
    logic        owned;
    logic [31:0] rdata;
    logic [31:0] mstatus_rd;
    logic        wr_ok;
    logic        illegal;
    logic        exc_take;
    logic [4:0]  exc_cause;
    logic [31:0] ip;
    logic        irq_take;
    logic [4:0]  irq_code;
    logic        trap;
    logic [4:0]  trap_code;
    logic        mret_ok;
    logic [31:0] vec_off;

    assign is_m       = (mode_q == PRIV_M);
    assign mstatus_rd = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

    always_comb begin
        rdata = '0;
        owned = 1'b1;
        case (csr.addr)
            ADDR_MSTATUS: rdata = mstatus_rd;
            ADDR_MIE:     rdata = mie_q;
            ADDR_MTVEC:   rdata = mtvec_q;
            ADDR_MEPC:    rdata = mepc_q;
            ADDR_MCAUSE:  rdata = mcause_q;
            ADDR_MTVAL:   rdata = mtval_q;
            ADDR_MIP:     rdata = mip_q;
            default:      owned = 1'b0;
        endcase
    end

    assign csr.rdata = rdata;

    // CSR writes from U-mode are dropped and turned into an illegal-instruction trap,
    // as is an MRET attempted from U-mode.
    assign wr_ok     = csr.wr_en & is_m;
    assign illegal   = (csr.wr_en & owned & ~is_m) | (en_i & mret_i & ~is_m);
    assign exc_take  = (en_i & exc_i) | illegal;
    assign exc_cause = (en_i & exc_i) ? exc_code_i : 5'd2;

    // U-mode always accepts interrupts; M-mode only with MIE set.
    assign ip       = mip_q & mie_q;
    assign irq_take = ((is_m & st_mie) | ~is_m) & (|ip);

    always_comb begin
        irq_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (ip[IRQ_CODE_BASE + i]) irq_code = 5'(IRQ_CODE_BASE + i);
        end
    end

    assign trap      = exc_take | irq_take;
    assign trap_code = exc_take ? exc_cause : irq_code;
    assign mret_ok   = en_i & mret_i & is_m & ~trap;
    assign vec_off   = (mtvec_q[0] & ~exc_take) ? {25'b0, trap_code, 2'b00} : 32'h0;

    assign trap_o        = trap;
    assign redirect_o    = trap | mret_ok;
    assign redirect_pc_o = mret_ok ? mepc_q : ({mtvec_q[31:2], 2'b00} + vec_off);
    assign mode_o        = mode_q;

    // Trap and MRET assignments come after the CSR write so they win on shared fields;
    // they are computed from the pre-write register values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= PRIV_M;
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            st_mpp   <= PRIV_M;
            mie_q    <= '0;
            mip_q    <= '0;
            mtvec_q  <= MTVEC_RST;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else begin
            mip_q <= 32'(irq_i) << IRQ_CODE_BASE;

            if (wr_ok) begin
                case (csr.addr)
                    ADDR_MSTATUS: begin
                        st_mie  <= csr.wdata[3];
                        st_mpie <= csr.wdata[7];
                        if (csr.wdata[12:11] == PRIV_M ||
                            (HAS_UMODE && csr.wdata[12:11] == PRIV_U))
                            st_mpp <= priv_t'(csr.wdata[12:11]);
                    end
                    ADDR_MIE:    mie_q    <= csr.wdata & IRQ_MASK;
                    ADDR_MTVEC:  mtvec_q  <= {csr.wdata[31:2], 1'b0, csr.wdata[0]};
                    ADDR_MEPC:   mepc_q   <= {csr.wdata[31:1], 1'b0};
                    ADDR_MCAUSE: mcause_q <= csr.wdata;
                    ADDR_MTVAL:  mtval_q  <= csr.wdata;
                    default: ;
                endcase
            end

            if (trap) begin
                mepc_q   <= pc_i;
                mcause_q <= exc_take ? {27'b0, trap_code} : {1'b1, 26'b0, trap_code};
                mtval_q  <= exc_take ? exc_tval_i : 32'h0;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                st_mpp   <= mode_q;
                mode_q   <= PRIV_M;
            end else if (mret_ok) begin
                mode_q  <= HAS_UMODE ? st_mpp : PRIV_M;
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                st_mpp  <= HAS_UMODE ? PRIV_U : PRIV_M;
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;
    localparam int          NI   = 4;
    localparam int          BASE = 16;
    localparam logic [31:0] MRST = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [31:0]   pc;
    logic          exc;
    logic [4:0]    exc_code;
    logic [31:0]   exc_tval;
    logic          mret;
    logic [NI-1:0] irq;
    logic          trap;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [1:0]    mode;

    csr_trap_unit_if bus ();

    csr_trap_unit #(
        .NUM_IRQ(NI), .IRQ_CODE_BASE(BASE), .MTVEC_RST(MRST), .HAS_UMODE(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pc_i(pc), .exc_i(exc),
        .exc_code_i(exc_code), .exc_tval_i(exc_tval), .mret_i(mret), .irq_i(irq),
        .csr(bus.slave), .trap_o(trap), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc), .mode_o(mode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept as plain values.
    int          s_mode  = 3;
    int          s_mie   = 0;
    int          s_mpie  = 0;
    int          s_mpp   = 3;
    logic [31:0] r_ie    = '0;
    logic [31:0] r_ip    = '0;
    logic [31:0] r_tvec  = MRST;
    logic [31:0] r_epc   = '0;
    logic [31:0] r_cause = '0;
    logic [31:0] r_tval  = '0;

    bit          e_trap, e_irq, e_mret, e_redir;
    int          e_code;
    logic [31:0] e_pc, e_rd;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } wvec_t;
    wvec_t tbl[13];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic predict();
        bit ext, ill, gl;
        int pend;
        ext  = en && exc;
        ill  = (s_mode == 0) &&
               ((bus.wr_en && (bus.addr inside {12'h300, 12'h304, 12'h305, 12'h341,
                                                12'h342, 12'h343, 12'h344})) || (en && mret));
        pend = -1;
        for (int i = 0; i < NI; i++)
            if (pend < 0 && r_ip[BASE+i] && r_ie[BASE+i]) pend = BASE + i;
        gl      = (s_mode == 3 && s_mie == 1) || s_mode == 0;
        e_irq   = !(ext || ill) && gl && pend >= 0;
        e_trap  = ext || ill || e_irq;
        e_code  = ext ? int'(exc_code) : (ill ? 2 : pend);
        e_mret  = !e_trap && en && mret && s_mode == 3;
        e_redir = e_trap || e_mret;
        e_pc    = e_mret ? r_epc
                         : (r_tvec & ~32'h3) + ((e_irq && r_tvec[0]) ? 32'(4 * e_code) : 32'h0);
        case (bus.addr)
            12'h300: e_rd = 32'(s_mpp * 2048 + s_mpie * 128 + s_mie * 8);
            12'h304: e_rd = r_ie;
            12'h305: e_rd = r_tvec;
            12'h341: e_rd = r_epc;
            12'h342: e_rd = r_cause;
            12'h343: e_rd = r_tval;
            12'h344: e_rd = r_ip;
            default: e_rd = '0;
        endcase
    endtask

    task automatic model_update();
        int o_mode, o_mie, o_mpie, o_mpp;
        if (rst) begin
            s_mode = 3; s_mie = 0; s_mpie = 0; s_mpp = 3;
            r_ie = '0; r_ip = '0; r_tvec = MRST; r_epc = '0; r_cause = '0; r_tval = '0;
            return;
        end
        o_mode = s_mode; o_mie = s_mie; o_mpie = s_mpie; o_mpp = s_mpp;
        if (bus.wr_en && s_mode == 3) begin
            case (bus.addr)
                12'h300: begin
                    s_mie  = int'(bus.wdata[3]);
                    s_mpie = int'(bus.wdata[7]);
                    if (bus.wdata[12:11] == 2'b00 || bus.wdata[12:11] == 2'b11)
                        s_mpp = int'(bus.wdata[12:11]);
                end
                12'h304: r_ie    = bus.wdata & 32'h000F_0000;
                12'h305: r_tvec  = bus.wdata & ~32'h2;
                12'h341: r_epc   = bus.wdata & ~32'h1;
                12'h342: r_cause = bus.wdata;
                12'h343: r_tval  = bus.wdata;
                default: ;
            endcase
        end
        if (e_trap) begin
            r_epc   = pc;
            r_cause = e_irq ? (32'h8000_0000 | 32'(e_code)) : 32'(e_code);
            r_tval  = e_irq ? 32'h0 : exc_tval;
            s_mpie  = o_mie;
            s_mie   = 0;
            s_mpp   = o_mode;
            s_mode  = 3;
        end else if (e_mret) begin
            s_mode = o_mpp;
            s_mie  = o_mpie;
            s_mpie = 1;
            s_mpp  = 0;
        end
        r_ip = 32'(irq) << BASE;
    endtask

    task automatic drive_check();
        #1;
        predict();
        chk("trap_o", 32'(trap), 32'(e_trap));
        chk("redirect_o", 32'(redirect), 32'(e_redir));
        if (e_redir) chk("redirect_pc_o", redirect_pc, e_pc);
        chk("csr_data_o", bus.rdata, e_rd);
        chk("mode_o", 32'(mode), 32'(s_mode));
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 0; exc = 0; mret = 0; exc_code = '0; exc_tval = '0;
        bus.wr_en = 0; bus.wdata = '0; bus.addr = 12'h7C0;
    endtask

    task automatic wr(logic [11:0] a, logic [31:0] d);
        idle();
        bus.addr = a; bus.wr_en = 1; bus.wdata = d;
        drive_check();
        clk_edge();
    endtask

    task automatic peek(string nm, logic [11:0] a, logic [31:0] exp);
        idle();
        bus.addr = a;
        drive_check();
        chk(nm, bus.rdata, exp);
        clk_edge();
    endtask

    initial begin
        tbl[0]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
        tbl[1]  = '{12'h300, 32'h0000_1000, 32'h0000_1800};
        tbl[2]  = '{12'h300, 32'h0000_0000, 32'h0000_0000};
        tbl[3]  = '{12'h300, 32'h0000_1800, 32'h0000_1800};
        tbl[4]  = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0000};
        tbl[5]  = '{12'h304, 32'h0000_0000, 32'h0000_0000};
        tbl[6]  = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[7]  = '{12'h305, 32'h0000_0103, 32'h0000_0101};
        tbl[8]  = '{12'h341, 32'h0000_0123, 32'h0000_0122};
        tbl[9]  = '{12'h342, 32'h8000_001F, 32'h8000_001F};
        tbl[10] = '{12'h343, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[11] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{12'h301, 32'hFFFF_FFFF, 32'h0000_0000};

        rst = 1; pc = 32'h1000; irq = '0;
        idle();
        clk_edge();
        rst = 0;

        // reset state
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        peek("rst_mtvec", 12'h305, MRST);
        peek("rst_mie", 12'h304, 32'h0);
        chk("rst_mode", 32'(mode), 32'h3);
        chk("rst_trap", 32'(trap), 32'h0);

        // write masking table
        for (int i = 0; i < 13; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            peek($sformatf("tbl%0d_readback", i), tbl[i].addr, tbl[i].exp);
        end

        // M-mode interrupt entry, mip latency
        wr(12'h304, 32'h0001_0000);
        wr(12'h300, 32'h0000_1808);
        idle(); irq = 4'b0001; pc = 32'h1000;
        drive_check();
        chk("irq0_latency_no_trap", 32'(trap), 32'h0);
        clk_edge();
        idle();
        drive_check();
        chk("irq0_trap", 32'(trap), 32'h1);
        chk("irq0_vec_pc", redirect_pc, 32'h0000_0140);
        clk_edge();
        irq = '0;
        peek("irq0_mcause", 12'h342, 32'h8000_0010);
        peek("irq0_mepc", 12'h341, 32'h0000_1000);
        peek("irq0_mstatus", 12'h300, 32'h0000_1880);

        // vectored interrupt, then exception beats interrupt
        wr(12'h300, 32'h0000_1808);
        wr(12'h304, 32'h000F_0000);
        idle(); irq = 4'b0100;
        drive_check();
        clk_edge();
        idle();
        drive_check();
        chk("irq2_vec_pc", redirect_pc, 32'h0000_0148);
        clk_edge();
        wr(12'h300, 32'h0000_1808);
        idle(); en = 1; exc = 1; exc_code = 5'd8; exc_tval = 32'h55;
        drive_check();
        chk("exc8_trap", 32'(trap), 32'h1);
        chk("exc8_pc", redirect_pc, 32'h0000_0100);
        clk_edge();
        irq = '0;
        peek("exc8_mcause", 12'h342, 32'h0000_0008);
        peek("exc8_mtval", 12'h343, 32'h0000_0055);

        // exception over two pending irqs, MRET, then lowest irq
        irq = 4'b1010;
        peek("pend_mip", 12'h344, 32'h0000_0000);
        wr(12'h300, 32'h0000_1808);
        idle(); en = 1; exc = 1; exc_code = 5'd2; pc = 32'h2000;
        drive_check();
        chk("exc2_pc", redirect_pc, 32'h0000_0100);
        clk_edge();
        idle(); en = 1; mret = 1; pc = 32'h2004;
        drive_check();
        chk("mret_no_trap", 32'(trap), 32'h0);
        chk("mret_pc", redirect_pc, 32'h0000_2000);
        clk_edge();
        idle();
        drive_check();
        chk("irq1_vec_pc", redirect_pc, 32'h0000_0144);
        clk_edge();
        irq = '0;
        peek("irq1_mcause", 12'h342, 32'h8000_0011);

        // MRET into U-mode, then illegal CSR write
        wr(12'h300, 32'h0000_0000);
        wr(12'h341, 32'h0000_0200);
        idle(); en = 1; mret = 1;
        drive_check();
        chk("mret_u_pc", redirect_pc, 32'h0000_0200);
        clk_edge();
        idle(); bus.addr = 12'h300; bus.wr_en = 1; bus.wdata = 32'h0000_1888; pc = 32'h0400;
        drive_check();
        chk("u_mode", 32'(mode), 32'h0);
        chk("u_wr_trap", 32'(trap), 32'h1);
        clk_edge();
        peek("u_wr_mstatus", 12'h300, 32'h0000_0000);
        peek("u_wr_mcause", 12'h342, 32'h0000_0002);
        chk("u_wr_mode", 32'(mode), 32'h3);

        // reset during a trap cycle
        idle(); en = 1; exc = 1; exc_code = 5'd5; pc = 32'h3000; rst = 1;
        drive_check();
        clk_edge();
        rst = 0;
        peek("rst_trap_mepc", 12'h341, 32'h0);
        peek("rst_trap_mcause", 12'h342, 32'h0);
        peek("rst_trap_mstatus", 12'h300, 32'h0000_1800);
        peek("rst_trap_mtvec", 12'h305, MRST);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [11:0] alist[8];
            alist = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
            rst       = ($urandom_range(0, 63) == 0);
            en        = 1'($urandom_range(0, 1));
            exc       = ($urandom_range(0, 7) == 0);
            exc_code  = 5'($urandom);
            exc_tval  = $urandom;
            mret      = ($urandom_range(0, 5) == 0);
            irq       = NI'($urandom);
            pc        = $urandom;
            bus.addr  = alist[$urandom_range(0, 7)];
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wdata = $urandom;
            drive_check();
            clk_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
